// File: rtl/gecko_reg_scoreboard_pkg.sv
// Shared gecko scoreboard types: register-status tag, register address and FSM state.
package gecko_reg_scoreboard_pkg;

   localparam int unsigned GeckoStatusWidth = 2;
   localparam int unsigned RegAddrWidth     = 5;

   typedef logic [GeckoStatusWidth-1:0] gecko_reg_status_t;
   typedef logic [RegAddrWidth-1:0]     rv32_reg_addr_t;

   typedef enum logic {INIT, RUN} gecko_scoreboard_state_t;

endpackage

// File: rtl/gecko_reg_status_table.sv
// Per-register wrap-around counter RAM: one clear port, one increment port, NUM_RD async reads.
module gecko_reg_status_table
   import gecko_reg_scoreboard_pkg::*;
#(
   parameter int unsigned STATUS_WIDTH = GeckoStatusWidth,
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned NUM_RD       = 3
) (
   input  logic                                      clk,
   input  logic                                      clr_en_i,
   input  logic [RegAddrWidth-1:0]                   clr_addr_i,
   input  logic                                      inc_en_i,
   input  logic [RegAddrWidth-1:0]                   inc_addr_i,
   input  logic [NUM_RD-1:0][RegAddrWidth-1:0]       rd_addr_i,
   output logic [NUM_RD-1:0][STATUS_WIDTH-1:0]       rd_data_o
);

   logic [STATUS_WIDTH-1:0] mem_q [NUM_REGS];

   // Clear wins; the two sources are never active together outside reset sweep.
   always_ff @(posedge clk) begin
      if (clr_en_i) begin
         mem_q[clr_addr_i] <= '0;
      end else if (inc_en_i) begin
         mem_q[inc_addr_i] <= mem_q[inc_addr_i] + 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_RD); i++) begin
         rd_data_o[i] = mem_q[rd_addr_i[i]];
      end
   end

endmodule

// File: rtl/gecko_reg_scoreboard.sv
// Issue-side register status tracker: tags issued writes per destination, retires them on
// writeback, flags pending sources, stalls on tag exhaustion and detects out-of-order retire.
module gecko_reg_scoreboard
   import gecko_reg_scoreboard_pkg::*;
#(
   parameter int unsigned STATUS_WIDTH = GeckoStatusWidth,
   parameter int unsigned NUM_REGS     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      init_done_o,
   input  logic                      issue_valid_i,
   output logic                      issue_ready_o,
   input  logic [RegAddrWidth-1:0]   issue_addr_i,
   output logic [STATUS_WIDTH-1:0]   issue_status_o,
   input  logic                      wb_valid_i,
   output logic                      wb_ready_o,
   input  logic [RegAddrWidth-1:0]   wb_addr_i,
   input  logic [STATUS_WIDTH-1:0]   wb_status_i,
   input  logic [RegAddrWidth-1:0]   rs1_addr_i,
   input  logic [RegAddrWidth-1:0]   rs2_addr_i,
   output logic                      rs1_pending_o,
   output logic                      rs2_pending_o,
   output logic                      order_error_o
);

   gecko_scoreboard_state_t state_q;
   logic [RegAddrWidth-1:0] sweep_q;
   logic                    init_done_q;
   logic                    order_error_q;

   logic                                  run;
   logic [2:0][RegAddrWidth-1:0]          front_rd_addr;
   logic [2:0][STATUS_WIDTH-1:0]          front_rd;
   logic [3:0][RegAddrWidth-1:0]          back_rd_addr;
   logic [3:0][STATUS_WIDTH-1:0]          back_rd;
   logic [STATUS_WIDTH-1:0]               front_next;
   logic                                  issue_x0, issue_full, issue_fire, wb_fire;

   assign run           = (state_q == RUN);
   assign front_rd_addr = {rs2_addr_i, rs1_addr_i, issue_addr_i};
   assign back_rd_addr  = {rs2_addr_i, rs1_addr_i, wb_addr_i, issue_addr_i};

   gecko_reg_status_table #(
      .STATUS_WIDTH (STATUS_WIDTH),
      .NUM_REGS     (NUM_REGS),
      .NUM_RD       (3)
   ) u_front (
      .clk        (clk),
      .clr_en_i   (!run),
      .clr_addr_i (sweep_q),
      .inc_en_i   (issue_fire),
      .inc_addr_i (issue_addr_i),
      .rd_addr_i  (front_rd_addr),
      .rd_data_o  (front_rd)
   );

   gecko_reg_status_table #(
      .STATUS_WIDTH (STATUS_WIDTH),
      .NUM_REGS     (NUM_REGS),
      .NUM_RD       (4)
   ) u_back (
      .clk        (clk),
      .clr_en_i   (!run),
      .clr_addr_i (sweep_q),
      .inc_en_i   (wb_fire),
      .inc_addr_i (wb_addr_i),
      .rd_addr_i  (back_rd_addr),
      .rd_data_o  (back_rd)
   );

   // Full when one more issue would make front catch up with back (all tags in flight).
   always_comb begin
      issue_x0       = (issue_addr_i == '0);
      front_next     = front_rd[0] + 1'b1;
      issue_full     = (front_next == back_rd[0]);
      issue_ready_o  = run && (issue_x0 || !issue_full);
      issue_status_o = issue_x0 ? '0 : front_rd[0];
      issue_fire     = issue_valid_i && issue_ready_o && !issue_x0;
      wb_fire        = wb_valid_i && run && (wb_addr_i != '0);
      wb_ready_o     = run;
      rs1_pending_o  = run && (rs1_addr_i != '0) && (front_rd[1] != back_rd[2]);
      rs2_pending_o  = run && (rs2_addr_i != '0) && (front_rd[2] != back_rd[3]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= INIT;
         sweep_q       <= '0;
         init_done_q   <= 1'b0;
         order_error_q <= 1'b0;
      end else begin
         unique case (state_q)
            INIT: begin
               sweep_q <= sweep_q + 1'b1;
               if (sweep_q == RegAddrWidth'(NUM_REGS - 1)) begin
                  state_q     <= RUN;
                  init_done_q <= 1'b1;
               end
            end
            RUN: begin
               if (wb_fire && (wb_status_i != back_rd[1])) begin
                  order_error_q <= 1'b1;
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end

   assign init_done_o   = init_done_q;
   assign order_error_o = order_error_q;

endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// Bench for gecko_reg_scoreboard: directed scenarios with literal checks plus a count-based
// model compared against the DUT every cycle, followed by a legal random issue/wb phase.
module tb_gecko_reg_scoreboard;

   localparam int Tags = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       init_done;
   logic       issue_valid = 1'b0;
   logic       issue_ready;
   logic [4:0] issue_addr = '0;
   logic [1:0] issue_status;
   logic       wb_valid = 1'b0;
   logic       wb_ready;
   logic [4:0] wb_addr = '0;
   logic [1:0] wb_status = '0;
   logic [4:0] rs1_addr = '0;
   logic [4:0] rs2_addr = '0;
   logic       rs1_pending, rs2_pending, order_error;

   int n_checks = 0;
   int n_errors = 0;

   gecko_reg_scoreboard dut (
      .clk            (clk),
      .rst            (rst),
      .init_done_o    (init_done),
      .issue_valid_i  (issue_valid),
      .issue_ready_o  (issue_ready),
      .issue_addr_i   (issue_addr),
      .issue_status_o (issue_status),
      .wb_valid_i     (wb_valid),
      .wb_ready_o     (wb_ready),
      .wb_addr_i      (wb_addr),
      .wb_status_i    (wb_status),
      .rs1_addr_i     (rs1_addr),
      .rs2_addr_i     (rs2_addr),
      .rs1_pending_o  (rs1_pending),
      .rs2_pending_o  (rs2_pending),
      .order_error_o  (order_error)
   );

   always #5 clk = ~clk;

   // Model: total writes issued / retired per register; tags are those totals mod Tags.
   int issued [32];
   int retired[32];
   bit m_run = 1'b0;
   int m_cnt = 0;
   bit m_err = 1'b0;

   function automatic int inflight(int r);
      return (((issued[r] - retired[r]) % Tags) + Tags) % Tags;
   endfunction

   function automatic bit pend(int r);
      return m_run && (r != 0) && ((issued[r] % Tags) != (retired[r] % Tags));
   endfunction

   task automatic check(string nm, int got, int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit do_iss;
      bit do_wb;
      if (rst) begin
         m_run = 1'b0;
         m_cnt = 0;
         m_err = 1'b0;
         for (int r = 0; r < 32; r++) begin
            issued[r]  = 0;
            retired[r] = 0;
         end
      end else if (!m_run) begin
         m_cnt++;
         if (m_cnt == 32) m_run = 1'b1;
      end else begin
         do_iss = issue_valid && (issue_addr != 0) && (inflight(int'(issue_addr)) != Tags - 1);
         do_wb  = wb_valid && (wb_addr != 0);
         if (do_wb) begin
            if (int'(wb_status) != retired[wb_addr] % Tags) m_err = 1'b1;
            retired[wb_addr]++;
         end
         if (do_iss) issued[issue_addr]++;
      end
   end

   initial begin
      bit exp_ready;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_ready = m_run && ((issue_addr == 0) || (inflight(int'(issue_addr)) != Tags - 1));
         check("m_init_done", int'(init_done), int'(m_run));
         check("m_wb_ready", int'(wb_ready), int'(m_run));
         check("m_issue_ready", int'(issue_ready), int'(exp_ready));
         if (m_run && exp_ready)
            check("m_issue_status", int'(issue_status),
                  (issue_addr == 0) ? 0 : issued[issue_addr] % Tags);
         check("m_rs1_pending", int'(rs1_pending), int'(pend(int'(rs1_addr))));
         check("m_rs2_pending", int'(rs2_pending), int'(pend(int'(rs2_addr))));
         check("m_order_error", int'(order_error), int'(m_err));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      wb_valid    = 1'b0;
   endtask

   task automatic wait_init(string nm);
      for (int i = 0; i < 32; i++) begin
         check({nm, "_init_done_low"}, int'(init_done), 0);
         check({nm, "_issue_ready_low"}, int'(issue_ready), 0);
         step();
      end
      check({nm, "_init_done_high"}, int'(init_done), 1);
   endtask

   initial begin
      int r;
      // 1: reset and init sweep
      step();
      step();
      rst        = 1'b0;
      issue_addr = 5'd5;
      rs1_addr   = 5'd5;
      rs2_addr   = 5'd7;
      wait_init("t1");
      check("t1_rs1_pending", int'(rs1_pending), 0);
      check("t1_rs2_pending", int'(rs2_pending), 0);

      // 2: tag exhaustion on x5
      issue_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t2_tag", int'(issue_status), i);
         step();
      end
      check("t2_full_ready", int'(issue_ready), 0);
      issue_valid = 1'b0;
      wb_valid    = 1'b1;
      wb_addr     = 5'd5;
      wb_status   = 2'd0;
      #1;
      check("t2_no_bypass", int'(issue_ready), 0);
      step();
      idle();
      #1;
      check("t2_ready_after_wb", int'(issue_ready), 1);
      check("t2_tag3", int'(issue_status), 3);

      // 3: pending on x7
      issue_valid = 1'b1;
      issue_addr  = 5'd7;
      rs1_addr    = 5'd7;
      #1;
      check("t3_pending_same_cycle", int'(rs1_pending), 0);
      step();
      idle();
      #1;
      check("t3_pending_set", int'(rs1_pending), 1);
      wb_valid  = 1'b1;
      wb_addr   = 5'd7;
      wb_status = 2'd0;
      step();
      idle();
      #1;
      check("t3_pending_clear", int'(rs1_pending), 0);
      check("t3_no_error", int'(order_error), 0);

      // 4: out-of-order writeback on x3
      issue_valid = 1'b1;
      issue_addr  = 5'd3;
      step();
      step();
      idle();
      wb_valid  = 1'b1;
      wb_addr   = 5'd3;
      wb_status = 2'd1;
      step();
      #1;
      check("t4_error_set", int'(order_error), 1);
      wb_status = 2'd1;
      step();
      idle();
      #1;
      check("t4_error_sticky", int'(order_error), 1);

      // 5: same-cycle issue and wb on x9
      issue_valid = 1'b1;
      issue_addr  = 5'd9;
      step();
      wb_valid  = 1'b1;
      wb_addr   = 5'd9;
      wb_status = 2'd0;
      step();
      idle();
      rs1_addr = 5'd9;
      #1;
      check("t5_pending", int'(rs1_pending), 1);
      check("t5_front2", int'(issue_status), 2);

      // x0 is untracked
      issue_valid = 1'b1;
      issue_addr  = 5'd0;
      rs1_addr    = 5'd0;
      #1;
      check("x0_ready", int'(issue_ready), 1);
      check("x0_tag", int'(issue_status), 0);
      check("x0_pending", int'(rs1_pending), 0);
      step();
      idle();

      // 6: reset mid-stream with x4 pending
      issue_valid = 1'b1;
      issue_addr  = 5'd4;
      rs1_addr    = 5'd4;
      step();
      idle();
      #1;
      check("t6_pending_before", int'(rs1_pending), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_init("t6");
      check("t6_pending_after", int'(rs1_pending), 0);
      check("t6_tag_after", int'(issue_status), 0);
      check("t6_error_cleared", int'(order_error), 0);

      // Random legal traffic on x0..x15, occasional wrong tag
      for (int c = 0; c < 10000; c++) begin
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_addr  = 5'($urandom_range(0, 15));
         rs1_addr    = 5'($urandom_range(0, 15));
         rs2_addr    = 5'($urandom_range(0, 15));
         r           = int'($urandom_range(1, 15));
         wb_valid    = (inflight(r) > 0) && ($urandom_range(0, 2) != 0);
         wb_addr     = 5'(r);
         wb_status   = 2'(retired[r] % Tags);
         if ($urandom_range(0, 499) == 0) wb_status = wb_status + 2'd1;
         step();
      end
      idle();
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
